// File: rtl/board_pkg.sv
// Shared board-level types and constants for the ROM fetch path.
package board_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rom_arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_SND = 1'b1
  } rom_requester_t;

  localparam logic [24:0] CPU_ROM_SDR_BASE = 25'h000000;
  localparam logic [24:0] SND_ROM_SDR_BASE = 25'h100000;

endpackage

// File: rtl/rom_word_cache.sv
// One-word last-fetch cache: tag compare, fill from SDRAM and flush.
module rom_word_cache #(
  parameter int TAG_W = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [15:0]      word,
  input  logic             fill_en,
  input  logic             fill_valid,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [15:0]      fill_word
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [15:0]      word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else begin
      if (fill_en) begin
        tag_q   <= fill_tag;
        word_q  <= fill_word;
        valid_q <= fill_valid;
      end
      // A flush arriving on the completion cycle must still leave the entry invalid.
      if (flush) valid_q <= 1'b0;
    end
  end

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign word = word_q;

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares one SDRAM ROM channel between the V33 CPU and the Z80 sound CPU,
// with a one-word cache per requester and round-robin miss arbitration.
module rom_fetch_arbiter
  import board_pkg::*;
#(
  parameter int                SDR_AW       = 25,
  parameter logic [SDR_AW-1:0] CPU_ROM_BASE = SDR_AW'(CPU_ROM_SDR_BASE),
  parameter logic [SDR_AW-1:0] SND_ROM_BASE = SDR_AW'(SND_ROM_SDR_BASE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              cpu_strobe,
  input  logic [19:0]       cpu_addr,
  output logic [15:0]       cpu_data,
  output logic              cpu_ready,
  input  logic              snd_strobe,
  input  logic [15:0]       snd_addr,
  output logic [7:0]        snd_data,
  output logic              snd_ready,
  output logic              sdr_req,
  input  logic              sdr_ack,
  output logic [SDR_AW-1:0] sdr_addr,
  input  logic [15:0]       sdr_data
);

  rom_arb_state_t    state_q;
  rom_requester_t    grant_q, last_grant_q, next_grant;
  logic              sdr_req_q;
  logic [SDR_AW-1:0] sdr_addr_q;
  logic              cpu_pend_q, snd_pend_q;
  logic [18:0]       cpu_tag_q;
  logic [15:0]       snd_addr_q;
  logic              flush_seen_q;
  logic              cpu_ready_q, snd_ready_q;
  logic [15:0]       cpu_data_q;
  logic [7:0]        snd_data_q;

  logic              cpu_hit_raw, snd_hit_raw;
  logic [15:0]       cpu_word, snd_word;
  logic              cpu_hit, cpu_miss, snd_hit, snd_miss;
  logic              complete, cpu_fill, snd_fill;
  logic [SDR_AW-1:0] cpu_sdr_addr, snd_sdr_addr;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = cpu_addr[0];

  rom_word_cache #(.TAG_W(19)) u_cpu_cache (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .lookup_tag (cpu_addr[19:1]),
    .hit        (cpu_hit_raw),
    .word       (cpu_word),
    .fill_en    (cpu_fill),
    .fill_valid (!flush_seen_q),
    .fill_tag   (cpu_tag_q),
    .fill_word  (sdr_data)
  );

  rom_word_cache #(.TAG_W(15)) u_snd_cache (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .lookup_tag (snd_addr[15:1]),
    .hit        (snd_hit_raw),
    .word       (snd_word),
    .fill_en    (snd_fill),
    .fill_valid (!flush_seen_q),
    .fill_tag   (snd_addr_q[15:1]),
    .fill_word  (sdr_data)
  );

  // Strobes while pending are protocol violations and are dropped entirely.
  assign cpu_hit  = cpu_strobe && !cpu_pend_q && cpu_hit_raw;
  assign cpu_miss = cpu_strobe && !cpu_pend_q && !cpu_hit_raw;
  assign snd_hit  = snd_strobe && !snd_pend_q && snd_hit_raw;
  assign snd_miss = snd_strobe && !snd_pend_q && !snd_hit_raw;

  assign complete = (state_q == WAIT) && (sdr_ack == sdr_req_q);
  assign cpu_fill = complete && (grant_q == REQ_CPU);
  assign snd_fill = complete && (grant_q == REQ_SND);

  assign cpu_sdr_addr = CPU_ROM_BASE + SDR_AW'({cpu_tag_q, 1'b0});
  assign snd_sdr_addr = SND_ROM_BASE + SDR_AW'({snd_addr_q[15:1], 1'b0});

  always_comb begin
    next_grant = REQ_SND;
    if (cpu_pend_q && snd_pend_q)
      next_grant = (last_grant_q == REQ_CPU) ? REQ_SND : REQ_CPU;
    else if (cpu_pend_q)
      next_grant = REQ_CPU;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= REQ_CPU;
      last_grant_q <= REQ_SND;
      sdr_req_q    <= 1'b0;
      sdr_addr_q   <= '0;
      cpu_pend_q   <= 1'b0;
      snd_pend_q   <= 1'b0;
      cpu_tag_q    <= '0;
      snd_addr_q   <= '0;
      flush_seen_q <= 1'b0;
      cpu_ready_q  <= 1'b0;
      snd_ready_q  <= 1'b0;
      cpu_data_q   <= '0;
      snd_data_q   <= '0;
    end else begin
      cpu_ready_q <= cpu_hit || cpu_fill;
      snd_ready_q <= snd_hit || snd_fill;
      if (cpu_hit)       cpu_data_q <= cpu_word;
      else if (cpu_fill) cpu_data_q <= sdr_data;
      if (snd_hit)       snd_data_q <= snd_addr[0] ? snd_word[15:8] : snd_word[7:0];
      else if (snd_fill) snd_data_q <= snd_addr_q[0] ? sdr_data[15:8] : sdr_data[7:0];

      if (cpu_miss) begin
        cpu_pend_q <= 1'b1;
        cpu_tag_q  <= cpu_addr[19:1];
      end else if (cpu_fill) begin
        cpu_pend_q <= 1'b0;
      end
      if (snd_miss) begin
        snd_pend_q <= 1'b1;
        snd_addr_q <= snd_addr;
      end else if (snd_fill) begin
        snd_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          flush_seen_q <= 1'b0;
          if (cpu_pend_q || snd_pend_q) begin
            grant_q    <= next_grant;
            sdr_addr_q <= (next_grant == REQ_CPU) ? cpu_sdr_addr : snd_sdr_addr;
            sdr_req_q  <= !sdr_req_q;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (complete) begin
            flush_seen_q <= 1'b0;
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end else if (flush) begin
            flush_seen_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sdr_req   = sdr_req_q;
  assign sdr_addr  = sdr_addr_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_data  = cpu_data_q;
  assign snd_ready = snd_ready_q;
  assign snd_data  = snd_data_q;

endmodule
